// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state type and helpers for the iterative divider
package div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} div_state_e;

  localparam int MAX_WIDTH = 256;

  function automatic int cnt_bits(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  // Widest divide-by-zero quotient; callers keep the low bits they need.
  function automatic logic [MAX_WIDTH-1:0] dbz_quotient();
    return '1;
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring division iteration
module div_step
  import div_pkg::*;
#(
  parameter int DIVISOR_WIDTH = 32
) (
  input  logic [DIVISOR_WIDTH:0]   prem_in,
  input  logic                     next_bit,
  input  logic [DIVISOR_WIDTH-1:0] dmag,
  output logic [DIVISOR_WIDTH:0]   prem_out,
  output logic                     q_bit
);

  logic [DIVISOR_WIDTH:0] shifted;
  logic [DIVISOR_WIDTH:0] dmag_ext;

  // The partial remainder stays below dmag, so its top bit only matters defensively.
  always_comb begin
    shifted  = {prem_in[DIVISOR_WIDTH-1:0], next_bit};
    dmag_ext = {1'b0, dmag};
    q_bit    = prem_in[DIVISOR_WIDTH] | (shifted >= dmag_ext);
    prem_out = q_bit ? (shifted - dmag_ext) : shifted;
  end

endmodule

// File: rtl/div_iter.sv
// rtl/div_iter.sv - iterative radix-2 signed/unsigned divider with valid/ready handshakes
module div_iter
  import div_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = 64,
  parameter int DIVISOR_WIDTH  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      is_signed,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIVIDEND_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      div_by_zero,
  output logic                      overflow
);

  localparam int CW = cnt_bits(DIVIDEND_WIDTH);
  localparam logic [MAX_WIDTH-1:0] DBZ_FULL = dbz_quotient();
  localparam logic [DIVIDEND_WIDTH-1:0] DBZ_Q = DBZ_FULL[DIVIDEND_WIDTH-1:0];
  localparam logic [DIVIDEND_WIDTH-1:0] MOST_NEG = {1'b1, {(DIVIDEND_WIDTH-1){1'b0}}};

  div_state_e                state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [DIVIDEND_WIDTH-1:0] work_q, work_d;
  logic [DIVISOR_WIDTH:0]    rem_q, rem_d;
  logic [DIVISOR_WIDTH-1:0]  dmag_q, dmag_d;
  logic                      q_neg_q, q_neg_d;
  logic                      r_neg_q, r_neg_d;
  logic [DIVIDEND_WIDTH-1:0] quotient_q, quotient_d;
  logic [DIVISOR_WIDTH-1:0]  remainder_q, remainder_d;
  logic                      dbz_q, dbz_d;
  logic                      ovf_q, ovf_d;
  logic                      out_valid_q, out_valid_d;

  logic                      dvd_neg, dsr_neg;
  logic [DIVISOR_WIDTH:0]    step_rem;
  logic                      step_qbit;

  div_step #(.DIVISOR_WIDTH(DIVISOR_WIDTH)) u_step (
    .prem_in  (rem_q),
    .next_bit (work_q[DIVIDEND_WIDTH-1]),
    .dmag     (dmag_q),
    .prem_out (step_rem),
    .q_bit    (step_qbit)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    rem_d       = rem_q;
    dmag_d      = dmag_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    dvd_neg     = is_signed & dividend[DIVIDEND_WIDTH-1];
    dsr_neg     = is_signed & divisor[DIVISOR_WIDTH-1];

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          work_d  = dvd_neg ? -dividend : dividend;
          dmag_d  = dsr_neg ? -divisor : divisor;
          rem_d   = '0;
          cnt_d   = CW'(DIVIDEND_WIDTH - 1);
          q_neg_d = dvd_neg ^ dsr_neg;
          r_neg_d = dvd_neg;
          if (divisor == '0) begin
            quotient_d  = DBZ_Q;
            remainder_d = dividend[DIVISOR_WIDTH-1:0];
            dbz_d       = 1'b1;
            state_d     = DONE;
          end else if (is_signed && dividend == MOST_NEG && divisor == '1) begin
            quotient_d  = MOST_NEG;
            remainder_d = '0;
            ovf_d       = 1'b1;
            state_d     = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        // Dividend bits leave at the top while quotient bits enter at the bottom.
        work_d = {work_q[DIVIDEND_WIDTH-2:0], step_qbit};
        rem_d  = step_rem;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = SIGN;
      end
      SIGN: begin
        quotient_d  = q_neg_q ? -work_q : work_q;
        remainder_d = r_neg_q ? -rem_q[DIVISOR_WIDTH-1:0] : rem_q[DIVISOR_WIDTH-1:0];
        state_d     = DONE;
      end
      DONE: begin
        out_valid_d = 1'b1;
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      rem_q       <= '0;
      dmag_q      <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      rem_q       <= rem_d;
      dmag_q      <= dmag_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_div_iter.sv
// tb/tb_div_iter.sv - directed self-checking bench for div_iter
module tb_div_iter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        is_signed = 1'b0;
  logic [63:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_iter dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .is_signed(is_signed), .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero), .overflow(overflow)
  );

  task automatic start_op(input logic s, input logic [63:0] a, input logic [31:0] b);
    @(negedge clk);
    is_signed = s; dividend = a; divisor = b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; is_signed = ~s; dividend = 64'h0123_4567_89AB_CDEF; divisor = 32'd3;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++; if (quotient !== 64'd0) begin errors++; $display("FAIL rst_quotient got %h want 0", quotient); end
    checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL rst_remainder got %h want 0", remainder); end
    checks++; if ({div_by_zero, overflow} !== 2'b00) begin errors++; $display("FAIL rst_flags got %b want 00", {div_by_zero, overflow}); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_unsigned();
    int n;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL u_in_ready got %b want 1", in_ready); end
    start_op(1'b0, 64'd100, 32'd7);
    wait_valid(n);
    checks++; if (n !== 66) begin errors++; $display("FAIL u_latency got %0d want 66", n); end
    checks++; if (quotient !== 64'd14) begin errors++; $display("FAIL u_quotient got %h want %h", quotient, 64'd14); end
    checks++; if (remainder !== 32'd2) begin errors++; $display("FAIL u_remainder got %h want %h", remainder, 32'd2); end
    checks++; if ({div_by_zero, overflow} !== 2'b00) begin errors++; $display("FAIL u_flags got %b want 00", {div_by_zero, overflow}); end
    consume();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL u_out_valid_drop got %b want 0", out_valid); end
    // 2^63 / (2^32-1) unsigned: same bits as the signed overflow case, but no overflow here
    start_op(1'b0, 64'h8000_0000_0000_0000, 32'hFFFF_FFFF);
    wait_valid(n);
    checks++; if (n !== 66) begin errors++; $display("FAIL u_big_latency got %0d want 66", n); end
    checks++; if (quotient !== 64'h8000_0000) begin errors++; $display("FAIL u_big_quotient got %h want %h", quotient, 64'h8000_0000); end
    checks++; if (remainder !== 32'h8000_0000) begin errors++; $display("FAIL u_big_remainder got %h want %h", remainder, 32'h8000_0000); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL u_big_overflow got %b want 0", overflow); end
    consume();
  endtask

  task automatic test_signed();
    int n;
    logic [63:0] a [5] = '{64'hFFFF_FFFF_FFFF_FF9C, 64'd100, 64'hFFFF_FFFF_FFFF_FF9C, 64'h0000_0100_0000_0000, 64'hFFFF_FF00_0000_0000};
    logic [31:0] b [5] = '{32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000};
    logic [63:0] eq [5] = '{64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFF2, 64'd14, 64'hFFFF_FFFF_FFFF_FE00, 64'd512};
    logic [31:0] er [5] = '{32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'd0};
    for (int i = 0; i < 5; i++) begin
      start_op(1'b1, a[i], b[i]);
      wait_valid(n);
      checks++; if (n !== 66) begin errors++; $display("FAIL s_latency[%0d] got %0d want 66", i, n); end
      checks++; if (quotient !== eq[i]) begin errors++; $display("FAIL s_quotient[%0d] got %h want %h", i, quotient, eq[i]); end
      checks++; if (remainder !== er[i]) begin errors++; $display("FAIL s_remainder[%0d] got %h want %h", i, remainder, er[i]); end
      checks++; if ({div_by_zero, overflow} !== 2'b00) begin errors++; $display("FAIL s_flags[%0d] got %b want 00", i, {div_by_zero, overflow}); end
      consume();
    end
  endtask

  task automatic test_div_zero();
    int n;
    for (int m = 0; m < 2; m++) begin
      start_op(m[0], 64'h1234, 32'd0);
      wait_valid(n);
      checks++; if (n !== 1) begin errors++; $display("FAIL dbz_latency[%0d] got %0d want 1", m, n); end
      checks++; if (quotient !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL dbz_quotient[%0d] got %h want all ones", m, quotient); end
      checks++; if (remainder !== 32'h1234) begin errors++; $display("FAIL dbz_remainder[%0d] got %h want 1234", m, remainder); end
      checks++; if ({div_by_zero, overflow} !== 2'b10) begin errors++; $display("FAIL dbz_flags[%0d] got %b want 10", m, {div_by_zero, overflow}); end
      consume();
    end
  endtask

  task automatic test_overflow();
    int n;
    start_op(1'b1, 64'h8000_0000_0000_0000, 32'hFFFF_FFFF);
    wait_valid(n);
    checks++; if (n !== 1) begin errors++; $display("FAIL ovf_latency got %0d want 1", n); end
    checks++; if (quotient !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL ovf_quotient got %h want 8000000000000000", quotient); end
    checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL ovf_remainder got %h want 0", remainder); end
    checks++; if ({div_by_zero, overflow} !== 2'b01) begin errors++; $display("FAIL ovf_flags got %b want 01", {div_by_zero, overflow}); end
    consume();
  endtask

  task automatic test_backpressure();
    int n;
    start_op(1'b0, 64'd1000, 32'd3);
    wait_valid(n);
    checks++; if (n !== 66) begin errors++; $display("FAIL bp_latency got %0d want 66", n); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b want 1", i, out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready); end
      checks++; if (quotient !== 64'd333) begin errors++; $display("FAIL bp_quotient[%0d] got %h want %h", i, quotient, 64'd333); end
      checks++; if (remainder !== 32'd1) begin errors++; $display("FAIL bp_remainder[%0d] got %h want 1", i, remainder); end
      in_valid = ~i[0]; is_signed = 1'b0; dividend = 64'd55 + 64'(i); divisor = 32'd0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    consume();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
    start_op(1'b0, 64'd77, 32'd5);
    wait_valid(n);
    checks++; if (n !== 66) begin errors++; $display("FAIL bp_next_latency got %0d want 66", n); end
    checks++; if (quotient !== 64'd15) begin errors++; $display("FAIL bp_next_quotient got %h want %h", quotient, 64'd15); end
    checks++; if (remainder !== 32'd2) begin errors++; $display("FAIL bp_next_remainder got %h want 2", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL bp_next_dbz got %b want 0", div_by_zero); end
    consume();
  endtask

  task automatic test_reset_mid();
    int n;
    start_op(1'b0, 64'd12345, 32'd11);
    repeat (20) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b want 0", out_valid); end
    checks++; if (quotient !== 64'd0) begin errors++; $display("FAIL mid_quotient got %h want 0", quotient); end
    checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL mid_remainder got %h want 0", remainder); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_release_ready got %b want 1", in_ready); end
    start_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF);
    wait_valid(n);
    checks++; if (n !== 66) begin errors++; $display("FAIL mid_next_latency got %0d want 66", n); end
    checks++; if (quotient !== 64'h1_0000_0001) begin errors++; $display("FAIL mid_next_quotient got %h want 100000001", quotient); end
    checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL mid_next_remainder got %h want 0", remainder); end
    consume();
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
